muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage, in parallel with the ALU. It consumes the same forwarded operands that the EX operand-select muxes deliver to the ALU. It computes all eight M-extension operations with a shift-add / restoring-division datapath. While it works, it holds the pipeline through `busy`.

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle between the operand muxes, the hazard
// logic and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring division on
// magnitudes, one bit per cycle, followed by a single sign-fixup cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [2:0]        f3_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   result_q;

  logic              a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result_d;

  // Operand decode for an incoming request
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:                         a_sgn = 1'b1;
      default:                        ;
    endcase
    neg_a = a_sgn & bus.op_a[XLEN-1];
    neg_b = b_sgn & bus.op_b[XLEN-1];
    a_abs = neg_a ? -bus.op_a : bus.op_a;
    b_abs = neg_b ? -bus.op_b : bus.op_b;

    div_zero = bus.funct3[2] && (bus.op_b == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    if (div_zero)
      special_res = bus.funct3[1] ? bus.op_a : '1;
    else
      special_res = bus.funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, m_q};
    if (f3_q[2]) begin
      if (div_diff[XLEN])
        acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot_fix = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 result_d = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_d = quot_fix;
      default:                result_d = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            f3_q <= bus.funct3;
            sa_q <= neg_a;
            sb_q <= neg_b;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              state_q  <= DONE;
            end else begin
              // Multiply iterates on |b| with |a| as multiplicand; divide on |a| by |b|
              m_q     <= bus.funct3[2] ? b_abs : a_abs;
              acc_q   <= {{XLEN{1'b0}}, bus.funct3[2] ? a_abs : b_abs};
              cnt_q   <= '0;
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31)
            state_q <= FIX;
        end
        FIX: begin
          result_q <= result_d;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_q == CALC) || (state_q == FIX);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
endmodule
